ahb_mem_arbiter: RTL and testbench
==================================

// Module: ahb_mem_arbiter
// PURPOSE
// - Two-master to one-slave AHB-Lite arbiter that shares one memory port between the core's dbus (m0) and ibus (m1).
// - Sits between the core's ibus/dbus and a unified memory/interconnect port.
// - Each master always has its address phase accepted at once; contention is absorbed by a one-entry pending buffer per master and by data-phase stalls.
// - Fixed priority to m0, with a starvation limit that guarantees m1 progress.
// PARAMETERS
// - ADDR_W        32  address width, all ports
// - DATA_W        32  data width, all ports
// - STARVE_LIMIT  4   consecutive contended m0 wins before m1 is forced a grant (>=1)
// PORTS
// - clk                    in   1       clock, all logic posedge
// - rst                    in   1       asynchronous, active-high reset
// - m0_htrans / m1_htrans  in   2       master transfer type; htrans[1]=1 is a request, forwarded as NONSEQ
// - m0_hwrite / m1_hwrite  in   1       master write flag
// - m0_hsize / m1_hsize    in   3       master transfer size
// - m0_haddr / m1_haddr    in   ADDR_W  master address
// - m0_hwdata / m1_hwdata  in   DATA_W  master write data (data phase)
// - m0_hready / m1_hready  out  1       per-master HREADY
// - m0_hresp / m1_hresp    out  1       per-master HRESP
// - m0_hrdata / m1_hrdata  out  DATA_W  read data, both driven from s_hrdata
// - s_htrans               out  2       slave transfer type: IDLE 2'b00 / NONSEQ 2'b10 only
// - s_hwrite               out  1       slave write flag
// - s_hsize                out  3       slave transfer size
// - s_haddr                out  ADDR_W  slave address
// - s_hwdata               out  DATA_W  slave write data, taken from the data-phase owner
// - s_hready               in   1       slave HREADYOUT
// - s_hresp                in   1       slave HRESP
// - s_hrdata               in   DATA_W  slave read data
// BEHAVIOUR
// - State: pb_valid[i] + pb_{addr,write,size}[i]; dp_valid, dp_owner; hold_q + aph_q (last presented address phase); streak counter of $clog2(STARVE_LIMIT+1) bits.
// - Reset (async): pb_valid=0, dp_valid=0, hold_q=0, streak=0. Outputs follow:
//   - s_htrans=IDLE
//   - m*_hready=1
//   - m*_hresp=0
// - Reset mid-transfer abandons all in-flight and buffered transfers.
// - hready_i (comb):
//   - = s_hready if dp_valid && dp_owner==i
//   - else 0 if pb_valid[i]
//   - else 1
// - live_i = hready_i && m_i_htrans[1]. cand_i = pb_valid[i] ? buffered request : live_i.
// - Arbitration, comb, only when !hold_q:
//   - winner = m1 if cand1 && (!cand0 || streak==STARVE_LIMIT)
//   - else m0 if cand0
//   - else none
// - Slave address phase:
//   - hold_q=1: s_* = aph_q.
//   - Otherwise s_* = winner's pb or live signals, or IDLE when no winner; aph_q <= s_*.
//   - hold_q <= s_htrans[1] && !s_hready.
// - Address accepted by slave when s_htrans[1] && s_hready:
//   - dp_valid<=1, dp_owner<=winner.
//   - Winner's pb_valid clears if the request came from pb.
// - s_hready=1 with no NONSEQ: dp_valid<=0.
// - Capture: a live request not forwarded-and-accepted this cycle sets pb_valid[i]<=1 and stores addr/write/size. This covers losing arbitration, hold_q, and s_hready=0.
// - One entry suffices: pb_valid[i] forces hready_i=0, so no new live request from i is possible.
// - Latency: uncontended live request reaches slave in the same cycle (zero added); buffered request goes out at the earliest free address slot.
// - s_hwdata = dp_owner ? m1_hwdata : m0_hwdata. Master holds hwdata while its hready is low.
// - m_i_hresp = dp_valid && dp_owner==i ? s_hresp : 0. Both cycles of a two-cycle ERROR pass through.
// - Streak, updated on accepted address only:
//   - m0 wins with cand1 set: streak+1.
//   - Otherwise: streak cleared.
// - Simultaneous: data phase of i completes (hready_i=1) while i presents its next address → arbitrated in that same cycle.
// - No combinational path from any m*_htrans to m*_hready.
// TESTING
// - Zero-wait, m1 read 0x100:
//   - s_haddr=0x100 NONSEQ same cycle.
//   - Next cycle: m1_hready=1, m1_hrdata=s_hrdata.
// - Same-cycle m0 write 0x200 (0xDEADBEEF) and m1 read 0x104:
//   - m0 forwarded; m1 buffered.
//   - m1_hready=0 one cycle; s_haddr=0x104 next cycle.
//   - s_hwdata=0xDEADBEEF during m0's data phase.
// - s_hready=0 for 2 cycles in m0's data phase, with m1 request pending:
//   - s_haddr/s_htrans stable across both cycles; m0_hready=0 both cycles.
//   - m1 request captured, not lost.
// - STARVE_LIMIT=4, both masters requesting continuously:
//   - Grant order m0,m0,m0,m0,m1,m0...; streak returns to 0.
// - s_hresp=1 for 2 cycles on m1 data phase: m1_hresp=1 both cycles, m0_hresp=0.
// - rst asserted with pb_valid[1]=1 and dp_valid=1:
//   - Immediately s_htrans=IDLE, m0_hready=m1_hready=1.
//   - No stale transfer issued after release.

Source files
------------

// File: rtl/ahb_mem_arbiter_if.sv
// ============================================================================
// Module   : ahb_mem_arbiter_if
// Purpose  : AHB-Lite port bundle for one side of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hready;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;

   modport master (
      output htrans, hwrite, hsize, haddr, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  htrans, hwrite, hsize, haddr, hwdata,
      output hready, hresp, hrdata
   );
endinterface

`default_nettype wire

// File: rtl/ahb_mem_arbiter.sv
// ============================================================================
// Module   : ahb_mem_arbiter
// Purpose  : Two-master (dbus m0, ibus m1) to one-slave AHB-Lite arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   ahb_mem_arbiter_if.slave  m0,
   ahb_mem_arbiter_if.slave  m1,
   ahb_mem_arbiter_if.master s
);
   localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
   localparam logic [1:0]          HT_IDLE    = 2'b00;
   localparam logic [1:0]          HT_NONSEQ  = 2'b10;

   logic [1:0]        m_req, m_write;
   logic [ADDR_W-1:0] m_addr [2];
   logic [2:0]        m_size [2];

   logic [1:0]        pb_valid_q, pb_valid_d, pb_write_q, pb_write_d;
   logic [ADDR_W-1:0] pb_addr_q [2];
   logic [ADDR_W-1:0] pb_addr_d [2];
   logic [2:0]        pb_size_q [2];
   logic [2:0]        pb_size_d [2];
   logic              dp_valid_q, dp_valid_d, dp_owner_q, dp_owner_d;
   logic              hold_q, hold_d;
   logic              aph_valid_q, aph_valid_d, aph_write_q, aph_write_d;
   logic [2:0]        aph_size_q, aph_size_d;
   logic [ADDR_W-1:0] aph_addr_q, aph_addr_d;
   logic              aph_owner_q, aph_owner_d, aph_m0c_q, aph_m0c_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic [1:0]        hready, live, cand, c_write, fwd_acc;
   logic [ADDR_W-1:0] c_addr [2];
   logic [2:0]        c_size [2];
   logic              win_valid, win_sel, accept, acc_owner, m0c;
   logic              s_valid, s_write;
   logic [2:0]        s_size;
   logic [ADDR_W-1:0] s_addr;
   logic              unused_htrans0;

   assign m_req   = {m1.htrans[1], m0.htrans[1]};
   assign m_write = {m1.hwrite, m0.hwrite};
   assign m_addr[0] = m0.haddr;
   assign m_addr[1] = m1.haddr;
   assign m_size[0] = m0.hsize;
   assign m_size[1] = m1.hsize;
   assign unused_htrans0 = m0.htrans[0] ^ m1.htrans[0];

   // hready depends only on registered state and s.hready, never on htrans
   for (genvar i = 0; i < 2; i++) begin : g_master
      assign hready[i]  = (dp_valid_q && (dp_owner_q == 1'(i))) ? s.hready : ~pb_valid_q[i];
      assign live[i]    = hready[i] & m_req[i];
      assign cand[i]    = pb_valid_q[i] | live[i];
      assign c_write[i] = pb_valid_q[i] ? pb_write_q[i] : m_write[i];
      assign c_addr[i]  = pb_valid_q[i] ? pb_addr_q[i]  : m_addr[i];
      assign c_size[i]  = pb_valid_q[i] ? pb_size_q[i]  : m_size[i];
      assign fwd_acc[i] = accept && !hold_q && (win_sel == 1'(i)) && !pb_valid_q[i];
   end

   assign win_valid = !hold_q && (cand[0] || cand[1]);
   assign win_sel   = cand[1] && (!cand[0] || (streak_q == STREAK_MAX));
   assign accept    = s_valid && s.hready;
   assign acc_owner = hold_q ? aph_owner_q : win_sel;
   assign m0c       = hold_q ? aph_m0c_q : (win_valid && !win_sel && cand[1]);

   always_comb begin
      s_valid = 1'b0;
      s_write = 1'b0;
      s_size  = '0;
      s_addr  = '0;
      if (hold_q) begin
         s_valid = aph_valid_q;
         s_write = aph_write_q;
         s_size  = aph_size_q;
         s_addr  = aph_addr_q;
      end else if (win_valid) begin
         s_valid = 1'b1;
         s_write = c_write[win_sel];
         s_size  = c_size[win_sel];
         s_addr  = c_addr[win_sel];
      end
   end

   always_comb begin
      hold_d      = s_valid && !s.hready;
      aph_valid_d = aph_valid_q;
      aph_write_d = aph_write_q;
      aph_size_d  = aph_size_q;
      aph_addr_d  = aph_addr_q;
      aph_owner_d = aph_owner_q;
      aph_m0c_d   = aph_m0c_q;
      if (!hold_q) begin
         aph_valid_d = s_valid;
         aph_write_d = s_write;
         aph_size_d  = s_size;
         aph_addr_d  = s_addr;
         aph_owner_d = win_sel;
         aph_m0c_d   = m0c;
      end

      dp_valid_d = dp_valid_q;
      dp_owner_d = dp_owner_q;
      if (accept) begin
         dp_valid_d = 1'b1;
         dp_owner_d = acc_owner;
      end else if (s.hready) begin
         dp_valid_d = 1'b0;
      end

      pb_valid_d = pb_valid_q;
      pb_write_d = pb_write_q;
      pb_addr_d  = pb_addr_q;
      pb_size_d  = pb_size_q;
      for (int i = 0; i < 2; i++) begin
         if (accept && (acc_owner == 1'(i))) begin
            pb_valid_d[i] = 1'b0;
         end
         if (live[i] && !fwd_acc[i]) begin
            pb_valid_d[i] = 1'b1;
            pb_write_d[i] = m_write[i];
            pb_addr_d[i]  = m_addr[i];
            pb_size_d[i]  = m_size[i];
         end
      end

      streak_d = streak_q;
      if (accept) begin
         streak_d = m0c ? streak_q + STREAK_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pb_valid_q  <= '0;
         pb_write_q  <= '0;
         pb_addr_q   <= '{default: '0};
         pb_size_q   <= '{default: '0};
         dp_valid_q  <= 1'b0;
         dp_owner_q  <= 1'b0;
         hold_q      <= 1'b0;
         aph_valid_q <= 1'b0;
         aph_write_q <= 1'b0;
         aph_size_q  <= '0;
         aph_addr_q  <= '0;
         aph_owner_q <= 1'b0;
         aph_m0c_q   <= 1'b0;
         streak_q    <= '0;
      end else begin
         pb_valid_q  <= pb_valid_d;
         pb_write_q  <= pb_write_d;
         pb_addr_q   <= pb_addr_d;
         pb_size_q   <= pb_size_d;
         dp_valid_q  <= dp_valid_d;
         dp_owner_q  <= dp_owner_d;
         hold_q      <= hold_d;
         aph_valid_q <= aph_valid_d;
         aph_write_q <= aph_write_d;
         aph_size_q  <= aph_size_d;
         aph_addr_q  <= aph_addr_d;
         aph_owner_q <= aph_owner_d;
         aph_m0c_q   <= aph_m0c_d;
         streak_q    <= streak_d;
      end
   end

   assign s.htrans = s_valid ? HT_NONSEQ : HT_IDLE;
   assign s.hwrite = s_write;
   assign s.hsize  = s_size;
   assign s.haddr  = s_addr;
   assign s.hwdata = dp_owner_q ? m1.hwdata : m0.hwdata;

   assign m0.hready = hready[0];
   assign m1.hready = hready[1];
   assign m0.hresp  = dp_valid_q && !dp_owner_q && s.hresp;
   assign m1.hresp  = dp_valid_q &&  dp_owner_q && s.hresp;
   assign m0.hrdata = s.hrdata;
   assign m1.hrdata = s.hrdata;
endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_arbiter.sv
// ============================================================================
// Module   : tb_ahb_mem_arbiter
// Purpose  : Directed self-checking bench for ahb_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   ahb_mem_arbiter_if m0_bus ();
   ahb_mem_arbiter_if m1_bus ();
   ahb_mem_arbiter_if s_bus ();

   ahb_mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .m0 (m0_bus),
      .m1 (m1_bus),
      .s  (s_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m0(input logic req, input logic [31:0] addr, input logic wr);
      m0_bus.htrans = req ? 2'b10 : 2'b00;
      m0_bus.haddr  = addr;
      m0_bus.hwrite = wr;
      m0_bus.hsize  = 3'b010;
   endtask

   task automatic drive_m1(input logic req, input logic [31:0] addr, input logic wr);
      m1_bus.htrans = req ? 2'b10 : 2'b00;
      m1_bus.haddr  = addr;
      m1_bus.hwrite = wr;
      m1_bus.hsize  = 3'b010;
   endtask

   initial begin
      drive_m0(1'b0, 32'h0, 1'b0);
      drive_m1(1'b0, 32'h0, 1'b0);
      m0_bus.hwdata = 32'h0;
      m1_bus.hwdata = 32'h0;
      s_bus.hready  = 1'b1;
      s_bus.hresp   = 1'b0;
      s_bus.hrdata  = 32'h0;

      // reset state
      #3;
      check("rst_htrans", 32'(s_bus.htrans), 32'h0);
      check("rst_m0_hready", 32'(m0_bus.hready), 32'h1);
      check("rst_m1_hready", 32'(m1_bus.hready), 32'h1);
      check("rst_m0_hresp", 32'(m0_bus.hresp), 32'h0);
      check("rst_m1_hresp", 32'(m1_bus.hresp), 32'h0);
      step();
      step();
      rst = 1'b0;

      // zero-wait m1 read
      step();
      drive_m1(1'b1, 32'h100, 1'b0);
      #2;
      check("t1_htrans", 32'(s_bus.htrans), 32'h2);
      check("t1_haddr", s_bus.haddr, 32'h100);
      check("t1_hwrite", 32'(s_bus.hwrite), 32'h0);
      step();
      drive_m1(1'b0, 32'h0, 1'b0);
      s_bus.hrdata = 32'h1122_3344;
      #2;
      check("t1_m1_hready", 32'(m1_bus.hready), 32'h1);
      check("t1_m1_hrdata", m1_bus.hrdata, 32'h1122_3344);
      check("t1_idle", 32'(s_bus.htrans), 32'h0);
      step();

      // simultaneous m0 write / m1 read
      step();
      drive_m0(1'b1, 32'h200, 1'b1);
      drive_m1(1'b1, 32'h104, 1'b0);
      #2;
      check("t2_haddr_m0", s_bus.haddr, 32'h200);
      check("t2_hwrite_m0", 32'(s_bus.hwrite), 32'h1);
      check("t2_hsize_m0", 32'(s_bus.hsize), 32'h2);
      step();
      drive_m0(1'b0, 32'h0, 1'b0);
      drive_m1(1'b0, 32'h0, 1'b0);
      m0_bus.hwdata = 32'hDEAD_BEEF;
      #2;
      check("t2_hwdata", s_bus.hwdata, 32'hDEAD_BEEF);
      check("t2_m0_hready", 32'(m0_bus.hready), 32'h1);
      check("t2_m1_hready_low", 32'(m1_bus.hready), 32'h0);
      check("t2_htrans_m1", 32'(s_bus.htrans), 32'h2);
      check("t2_haddr_m1", s_bus.haddr, 32'h104);
      check("t2_hwrite_m1", 32'(s_bus.hwrite), 32'h0);
      step();
      #2;
      check("t2_m1_done", 32'(m1_bus.hready), 32'h1);
      check("t2_idle", 32'(s_bus.htrans), 32'h0);
      step();

      // slave wait states in m0 data phase with m1 request arriving
      step();
      drive_m0(1'b1, 32'h300, 1'b0);
      #2;
      check("t3_haddr_m0", s_bus.haddr, 32'h300);
      step();
      drive_m0(1'b0, 32'h0, 1'b0);
      drive_m1(1'b1, 32'h304, 1'b0);
      s_bus.hready = 1'b0;
      #2;
      check("t3_w1_m0_hready", 32'(m0_bus.hready), 32'h0);
      check("t3_w1_htrans", 32'(s_bus.htrans), 32'h2);
      check("t3_w1_haddr", s_bus.haddr, 32'h304);
      step();
      drive_m1(1'b0, 32'h0, 1'b0);
      #2;
      check("t3_w2_m0_hready", 32'(m0_bus.hready), 32'h0);
      check("t3_w2_htrans", 32'(s_bus.htrans), 32'h2);
      check("t3_w2_haddr", s_bus.haddr, 32'h304);
      check("t3_w2_m1_hready", 32'(m1_bus.hready), 32'h0);
      step();
      s_bus.hready = 1'b1;
      #2;
      check("t3_rel_m0_hready", 32'(m0_bus.hready), 32'h1);
      check("t3_rel_m1_hready", 32'(m1_bus.hready), 32'h0);
      check("t3_rel_haddr", s_bus.haddr, 32'h304);
      check("t3_rel_htrans", 32'(s_bus.htrans), 32'h2);
      step();
      #2;
      check("t3_m1_done", 32'(m1_bus.hready), 32'h1);
      check("t3_idle", 32'(s_bus.htrans), 32'h0);
      step();

      // starvation limit: both request every cycle, m1 forced in every fifth slot
      for (int k = 0; k < 10; k++) begin
         step();
         drive_m0(1'b1, 32'h400, 1'b0);
         drive_m1(1'b1, 32'h500, 1'b0);
         #2;
         check($sformatf("t4_grant%0d", k), s_bus.haddr,
               ((k == 4) || (k == 9)) ? 32'h500 : 32'h400);
      end
      step();
      drive_m0(1'b0, 32'h0, 1'b0);
      drive_m1(1'b0, 32'h0, 1'b0);
      #2;
      check("t4_m0_pending", s_bus.haddr, 32'h400);
      check("t4_m0_pending_tr", 32'(s_bus.htrans), 32'h2);
      step();
      step();

      // two-cycle ERROR response on m1 data phase
      step();
      drive_m1(1'b1, 32'h600, 1'b0);
      #2;
      check("t5_haddr", s_bus.haddr, 32'h600);
      step();
      drive_m1(1'b0, 32'h0, 1'b0);
      s_bus.hresp  = 1'b1;
      s_bus.hready = 1'b0;
      #2;
      check("t5_e1_m1_hresp", 32'(m1_bus.hresp), 32'h1);
      check("t5_e1_m0_hresp", 32'(m0_bus.hresp), 32'h0);
      check("t5_e1_m1_hready", 32'(m1_bus.hready), 32'h0);
      step();
      s_bus.hready = 1'b1;
      #2;
      check("t5_e2_m1_hresp", 32'(m1_bus.hresp), 32'h1);
      check("t5_e2_m0_hresp", 32'(m0_bus.hresp), 32'h0);
      check("t5_e2_m1_hready", 32'(m1_bus.hready), 32'h1);
      step();
      s_bus.hresp = 1'b0;
      #2;
      check("t5_after_hresp", 32'(m1_bus.hresp), 32'h0);
      step();

      // reset while m0 is in data phase and m1 is buffered
      step();
      drive_m0(1'b1, 32'h700, 1'b1);
      drive_m1(1'b1, 32'h704, 1'b0);
      #2;
      check("t6_haddr_m0", s_bus.haddr, 32'h700);
      step();
      drive_m0(1'b0, 32'h0, 1'b0);
      drive_m1(1'b0, 32'h0, 1'b0);
      #1;
      check("t6_pre_m1_hready", 32'(m1_bus.hready), 32'h0);
      check("t6_pre_htrans", 32'(s_bus.htrans), 32'h2);
      rst = 1'b1;
      #1;
      check("t6_rst_htrans", 32'(s_bus.htrans), 32'h0);
      check("t6_rst_m0_hready", 32'(m0_bus.hready), 32'h1);
      check("t6_rst_m1_hready", 32'(m1_bus.hready), 32'h1);
      step();
      rst = 1'b0;
      #2;
      check("t6_post_htrans0", 32'(s_bus.htrans), 32'h0);
      step();
      #2;
      check("t6_post_htrans1", 32'(s_bus.htrans), 32'h0);
      check("t6_post_m1_hready", 32'(m1_bus.hready), 32'h1);
      check("t6_post_m0_hready", 32'(m0_bus.hready), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
